// File: rtl/clock_pkg.sv
// Shared constants for the multiplexed six-digit clock display.
// Segment patterns are active-high, bit6..bit0 = g,f,e,d,c,b,a.
package clock_pkg;
   localparam int NUM_DIGITS = 6;

   localparam logic [2:0] SLOT_COLON_A = 3'd2;
   localparam logic [2:0] SLOT_COLON_B = 3'd4;
   localparam logic [2:0] SLOT_LAST    = 3'd5;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high; non-BCD codes show a dash.
module bcd_to_7seg
   import clock_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);
   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0: seg_o = SEG_0;
         4'd1: seg_o = SEG_1;
         4'd2: seg_o = SEG_2;
         4'd3: seg_o = SEG_3;
         4'd4: seg_o = SEG_4;
         4'd5: seg_o = SEG_5;
         4'd6: seg_o = SEG_6;
         4'd7: seg_o = SEG_7;
         4'd8: seg_o = SEG_8;
         4'd9: seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed display scanner with per-slot blanking, frame-level
// digit snapshot, leading-zero suppression and a blinking colon.
module clock_display_scan
   import clock_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick_1hz,
   input  logic [3:0]            h_tens,
   input  logic [3:0]            h_ones,
   input  logic [3:0]            m_tens,
   input  logic [3:0]            m_ones,
   input  logic [3:0]            s_tens,
   input  logic [3:0]            s_ones,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);
   localparam int            PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] TERM    = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYC);
   localparam logic          POL     = (ACTIVE_LOW != 0);

   logic [PW-1:0]                presc_q;
   logic [2:0]                   slot_q;
   logic                         colon_q;
   logic [NUM_DIGITS-1:0][3:0]   shd_q;
   logic [NUM_DIGITS-1:0]        an_q,  an_d;
   logic [6:0]                   seg_q, seg_d;
   logic                         dp_q,  dp_d;

   logic [3:0] digit_sel;
   logic [6:0] dec_seg;
   logic       lit;

   always_comb begin
      digit_sel = shd_q[5];
      case (slot_q)
         3'd0: digit_sel = shd_q[0];
         3'd1: digit_sel = shd_q[1];
         3'd2: digit_sel = shd_q[2];
         3'd3: digit_sel = shd_q[3];
         3'd4: digit_sel = shd_q[4];
         default: digit_sel = shd_q[5];
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd_i (digit_sel),
      .seg_o (dec_seg)
   );

   // Everything is computed lit-high; polarity is applied only at the registers.
   always_comb begin
      lit   = (presc_q >= BLANK_P);
      an_d  = '0;
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
      if (lit) begin
         an_d = NUM_DIGITS'(1) << slot_q;
         if (!(slot_q == SLOT_LAST && digit_sel == 4'd0))
            seg_d = dec_seg;
         dp_d = colon_q && (slot_q == SLOT_COLON_A || slot_q == SLOT_COLON_B);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
         slot_q  <= '0;
         colon_q <= 1'b0;
         shd_q   <= '0;
         an_q    <= {NUM_DIGITS{POL}};
         seg_q   <= {7{POL}};
         dp_q    <= POL;
      end else begin
         an_q  <= an_d ^ {NUM_DIGITS{POL}};
         seg_q <= seg_d ^ {7{POL}};
         dp_q  <= dp_d ^ POL;
         if (tick_1hz)
            colon_q <= ~colon_q;
         if (presc_q == TERM) begin
            presc_q <= '0;
            if (slot_q == SLOT_LAST) begin
               slot_q <= '0;
               shd_q  <= {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};
            end else begin
               slot_q <= slot_q + 3'd1;
            end
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;
endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 16, anti-ghost cycles at start of each slot, all digits off (legal range 1..SCAN_DIV-2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 = an/seg/dp drive 0 when lit, 0 = drive 1 when lit.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tick_1hz  input  1  one-clk-wide enable pulse, once per second.
REQ-007 h_tens, h_ones, m_tens, m_ones, s_tens, s_ones  input  4 each  BCD time digits from the counter chain.
REQ-008 an  output  6  digit enables; bit0 = s_ones ... bit5 = h_tens.
REQ-009 seg  output  7  segments, bit6..bit0 = g,f,e,d,c,b,a.
REQ-010 dp  output  1  decimal point, used as the colon.

Function
REQ-011 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count, wrap to 0 and advance slot index 0..5, 5 wrapping to 0.
REQ-012 SHALL snapshot all six input digits into shadow registers in the cycle the slot index wraps 5->0; no other cycle updates the shadows, which prevents mid-frame tearing.
REQ-013 When prescaler < BLANK_CYC, an, seg and dp SHALL all be inactive.
REQ-014 When prescaler >= BLANK_CYC, exactly one an bit SHALL be active: the bit equal to slot index.
REQ-015 seg SHALL show the 7-segment pattern of the selected shadow digit (standard 0-9 patterns; 7 = a,b,c; 9 includes d).
REQ-016 A shadow digit > 9 SHALL show segment g only (dash).
REQ-017 Slot 5 with shadow h_tens == 0 SHALL show all segments off, with an[5] still asserted (leading-zero blanking).
REQ-018 SHALL keep a colon-phase flag that toggles on every tick_1hz.
REQ-019 dp SHALL be lit only in slots 2 and 4 while colon phase = 1 and outside the blank window.
REQ-020 an, seg and dp SHALL be registered outputs, one clk after the prescaler/index state that selects them.
REQ-021 tick_1hz coinciding with a slot or frame wrap SHALL be applied normally; the events are independent.
REQ-022 ACTIVE_LOW SHALL only invert the output drive; internal behaviour is identical for both settings.

Reset
REQ-023 While rst = 0, the following SHALL be held: prescaler 0, slot index 0, colon phase 0, shadows 0, an/seg/dp inactive.
REQ-024 Reset assertion mid-slot SHALL force the outputs inactive immediately, asynchronously.
REQ-025 After release, the first active output SHALL be an[0] at prescaler = BLANK_CYC, showing shadow 0 until the first frame wrap.

Structure
REQ-026 Shared package/include clock_pkg SHALL hold:
- the 7-segment pattern constants (0-9, dash, off);
- NUM_DIGITS = 6;
- slot index constants for the colon slots.
REQ-027 The decoder SHALL be the sub-module bcd_to_7seg (4-bit in, 7-bit active-high out, purely combinational), instantiated once on the muxed digit.
REQ-028 Polarity inversion SHALL be applied only at the output registers.

Verification
Bench parameters: SCAN_DIV = 8, BLANK_CYC = 2, ACTIVE_LOW = 1.
REQ-029 Reset release, inputs 12:34:56 -> first frame shows digits 0, with slot 5 blank. From the second frame:
- an cycles 111110 ... 011111, each active 6 of 8 cycles;
- slot 0 seg = 0000010 (6);
- slot 5 seg = 1111001 (1).
REQ-030 Inputs change from 12:34:56 to 12:34:57 mid-frame -> the remainder of the frame still shows 6 in slot 0; 7 appears only after the next 5->0 wrap.
REQ-031 h_tens = 0, h_ones = 9 -> an[5] = 0 and seg = 1111111 in slot 5; slot 4 seg = 0010000 (9).
REQ-032 Pulse tick_1hz once -> dp = 0 in slots 2 and 4 only, outside the blank window. A second pulse -> dp = 1 everywhere.
REQ-033 s_ones = 4'hC -> slot 0 seg = 0111111 (dash).
REQ-034 Assert rst in slot 3 at prescaler 5 -> an = 111111, seg = 1111111 and dp = 1 within the same cycle, with no clk edge needed. After release, restart per REQ-025.
